// File: rtl/main_ram_axil.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | main_ram_axil : AXI4-Lite read-only port onto a word RAM, plus backdoor write |
// | Define MAIN_RAM_AXIL_ADDR_CHECK_EN to answer out-of-range reads with SLVERR.  |
// | Revision 1.0                                                                  |
// +-----------------------------------------------------------------------------+

module main_ram_axil #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     write_en,
   input  logic [$clog2(DEPTH)-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0]    write_data,
   input  logic [ADDR_WIDTH-1:0]    ARADDR,
   input  logic                     ARVALID,
   output logic                     ARREADY,
   output logic [DATA_WIDTH-1:0]    RDATA,
   output logic [1:0]               RRESP,
   output logic                     RVALID,
   input  logic                     RREADY
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OFFS  = $clog2(DATA_WIDTH / 8);
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, next_state;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      addr_q;
   logic                  oor_q;
   logic [IDX_W-1:0]      ar_idx;
   logic                  ar_oor;
   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_oor;
   logic                  enter_resp;
   logic                  unused_addr_bits;

   assign ar_idx = ARADDR[OFFS +: IDX_W];

`ifdef MAIN_RAM_AXIL_ADDR_CHECK_EN
   assign ar_oor = |ARADDR[ADDR_WIDTH-1:OFFS+IDX_W];
`else
   assign ar_oor = 1'b0;
`endif

   assign unused_addr_bits = ^{ARADDR[OFFS-1:0], ARADDR[ADDR_WIDTH-1:OFFS+IDX_W]};

   // With a latency of one, RESP is entered on the handshake edge itself, so the
   // address has to come straight from the bus instead of the capture register.
   assign rd_idx = (state == IDLE) ? ar_idx : addr_q;
   assign rd_oor = (state == IDLE) ? ar_oor : oor_q;

   assign ARREADY    = (state == IDLE);
   assign RVALID     = (state == RESP);
   assign enter_resp = (state != RESP) && (next_state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (ARVALID) begin
               next_state = (READ_LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt == CNT_ONE) begin
               next_state = RESP;
            end
         end
         RESP: begin
            if (RREADY) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         addr_q <= '0;
         oor_q  <= 1'b0;
         RDATA  <= '0;
         RRESP  <= 2'b00;
      end else begin
         if (state == IDLE && ARVALID) begin
            addr_q <= ar_idx;
            oor_q  <= ar_oor;
            cnt    <= LAT_M1;
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_ONE;
         end
         // Memory is sampled before this edge's backdoor write lands.
         if (enter_resp) begin
            RDATA <= rd_oor ? '0 : mem[rd_idx];
            RRESP <= rd_oor ? 2'b10 : 2'b00;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && write_en) begin
         mem[write_addr] <= write_data;
      end
   end

endmodule

`default_nettype wire
